// File: rtl/ps2_rx_pkg.sv
// Shared constants for the PS/2 receive path.
package ps2_rx_pkg;

    // Start + 8 data + parity + stop
    localparam int FRAME_BITS         = 11;
    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_FILTER_LEN = 8;

    // Bit counter value loaded on the start edge; counts down to 0 on the stop edge
    localparam logic [3:0] LAST_BIT_CNT = 4'(FRAME_BITS - 2);

endpackage

// File: rtl/ps2_rx_clk_filter.sv
// PS/2 clock conditioning: 2-flop synchroniser, glitch filter and a
// one-cycle pulse on every filtered falling edge. Shared with the transmitter.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic fall
);

    logic                  c_meta;
    logic                  c_sync;
    logic [FILTER_LEN-1:0] filter;
    logic                  f_c_reg;
    logic                  f_c_next;

    // Synchronise the pad clock and shift it through the filter; idle bus is high
    always_ff @(posedge clk) begin
        if (reset) begin
            c_meta  <= 1'b1;
            c_sync  <= 1'b1;
            filter  <= '1;
            f_c_reg <= 1'b1;
        end else begin
            c_meta  <= ps2c;
            c_sync  <= c_meta;
            filter  <= {c_sync, filter[FILTER_LEN-1:1]};
            f_c_reg <= f_c_next;
        end
    end

    // Filtered level only changes once the whole window agrees
    always_comb begin
        f_c_next = f_c_reg;
        if (&filter)
            f_c_next = 1'b1;
        else if (~|filter)
            f_c_next = 1'b0;
    end

    assign fall = f_c_reg & ~f_c_next;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: collects an 11-bit frame on filtered
// falling edges and presents the data byte with a one-cycle done strobe.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2d,
    input  logic                 ps2c,
    input  logic                 rx_en,
    output logic                 rx_idle,
    output logic                 rx_done_tick,
    output logic [DATA_BITS-1:0] dout
);

    // Frame states: IDLE waits for a start edge, DPS shifts bits, LOAD strobes done
    typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

    state_t                state;
    logic [3:0]            n;
    logic [FRAME_BITS-1:0] b;
    logic                  d_meta;
    logic                  d_sync;
    logic                  fall;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .ps2c  (ps2c),
        .fall  (fall)
    );

    // Synchronise the data line; same latency as the clock path's synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            d_meta <= ps2d;
            d_sync <= d_meta;
        end
    end

    // Frame FSM with registered idle/done outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            n            <= '0;
            b            <= '0;
            rx_idle      <= 1'b1;
            rx_done_tick <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && rx_en) begin
                        b       <= {d_sync, b[FRAME_BITS-1:1]};
                        n       <= LAST_BIT_CNT;
                        state   <= DPS;
                        rx_idle <= 1'b0;
                    end
                end
                DPS: begin
                    // A started frame always runs to completion, regardless of rx_en
                    if (fall) begin
                        b <= {d_sync, b[FRAME_BITS-1:1]};
                        if (n == 4'd0) begin
                            state        <= LOAD;
                            rx_done_tick <= 1'b1;
                        end else begin
                            n <= n - 4'd1;
                        end
                    end
                end
                LOAD: begin
                    state   <= IDLE;
                    rx_idle <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    rx_idle <= 1'b1;
                end
            endcase
        end
    end

    assign dout = b[DATA_BITS:1];

endmodule

// File: tb/tb_ps2_rx.sv
// Directed + randomised bench for ps2_rx, checked against a byte-level model.
module tb_ps2_rx;

    localparam int HALF = 40;   // ps2c half period in clk cycles (80x ratio)

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2d = 1'b1;
    logic       ps2c = 1'b1;
    logic       rx_en = 1'b1;
    logic       rx_idle;
    logic       rx_done_tick;
    logic [7:0] dout;

    int total = 0;
    int bad = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    ps2_rx dut (
        .clk          (clk),
        .reset        (reset),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_en        (rx_en),
        .rx_idle      (rx_idle),
        .rx_done_tick (rx_done_tick),
        .dout         (dout)
    );

    always #10 clk = ~clk;

    // Record every cycle the strobe is high together with the byte presented
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1)
            got_q.push_back(dout);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] data, input logic bad_par);
        logic p;
        p = (~^data) ^ bad_par;
        return {1'b1, p, data, 1'b0};
    endfunction

    task automatic send_bit(input logic v);
        @(negedge clk);
        ps2d = v;
        repeat (10) @(negedge clk);
        ps2c = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
        repeat (HALF - 10) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] fr, input int from, input int upto);
        for (int i = from; i <= upto; i++)
            send_bit(fr[i]);
        @(negedge clk);
        ps2d = 1'b1;
    endtask

    // Full frame plus comparison of tick count and last byte against the model
    task automatic frame_and_check(input string tag, input logic [7:0] data, input logic bad_par);
        send_bits(make_frame(data, bad_par), 0, 10);
        exp_q.push_back(data);
        repeat (20) @(negedge clk);
        chk({tag, "_ticks"}, got_q.size(), exp_q.size());
        if (got_q.size() > 0)
            chk({tag, "_dout"}, got_q[got_q.size()-1], data);
        chk({tag, "_idle"}, rx_idle, 1'b1);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rf;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_idle", rx_idle, 1'b1);
        chk("rst_dout", dout, 8'h00);
        chk("rst_tick", rx_done_tick, 1'b0);

        // Scenario 1: 0x1C, busy mid-frame
        send_bits(make_frame(8'h1C, 1'b0), 0, 4);
        repeat (5) @(negedge clk);
        chk("s1_busy", rx_idle, 1'b0);
        chk("s1_noearly", got_q.size(), 0);
        send_bits(make_frame(8'h1C, 1'b0), 5, 10);
        exp_q.push_back(8'h1C);
        repeat (20) @(negedge clk);
        chk("s1_ticks", got_q.size(), exp_q.size());
        if (got_q.size() > 0)
            chk("s1_dout", got_q[got_q.size()-1], 8'h1C);
        chk("s1_idle", rx_idle, 1'b1);

        // Scenario 2: back-to-back
        frame_and_check("s2a", 8'hF0, 1'b0);
        frame_and_check("s2b", 8'h1C, 1'b0);

        // Scenario 3: short low glitches on an idle bus
        for (int g = 0; g < 6; g++) begin
            ps2c = 1'b0;
            repeat (3) @(negedge clk);
            ps2c = 1'b1;
            repeat (30) @(negedge clk);
            chk("s3_idle", rx_idle, 1'b1);
        end
        chk("s3_ticks", got_q.size(), exp_q.size());

        // Scenario 4: frame ignored while disabled, then accepted
        rx_en = 1'b0;
        send_bits(make_frame(8'hFA, 1'b0), 0, 5);
        chk("s4_idle_mid", rx_idle, 1'b1);
        send_bits(make_frame(8'hFA, 1'b0), 6, 10);
        repeat (20) @(negedge clk);
        chk("s4_ticks", got_q.size(), exp_q.size());
        chk("s4_idle", rx_idle, 1'b1);
        rx_en = 1'b1;
        frame_and_check("s4_aa", 8'hAA, 1'b0);

        // Scenario 5: reset mid-frame, then a clean 0x00 frame
        send_bits(make_frame(8'h00, 1'b0), 0, 4);
        repeat (5) @(negedge clk);
        chk("s5_busy", rx_idle, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("s5_idle", rx_idle, 1'b1);
        chk("s5_dout", dout, 8'h00);
        chk("s5_ticks", got_q.size(), exp_q.size());
        frame_and_check("s5_00", 8'h00, 1'b0);

        // Scenario 6: wrong parity still accepted
        frame_and_check("s6_08", 8'h08, 1'b1);

        // Random bytes with random parity errors
        for (int r = 0; r < 6; r++) begin
            rd = 8'($urandom_range(0, 255));
            rf = 1'($urandom_range(0, 1));
            frame_and_check("rnd", rd, rf);
        end

        // Whole received sequence against the model
        chk("seq_len", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk("seq_byte", got_q[k], exp_q[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
